// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch / memory-access port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned STARVE_LIMIT_DEFAULT = 3;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_MA   = 2'd2
  } resp_owner_e;

  // Starvation counter must hold STARVE_LIMIT and is never narrower than 2 bits.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return ($clog2(limit + 1) < 2) ? 2 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// Grant selection: memory-access wins by default, fetch is forced through
// after STARVE_LIMIT consecutive denied cycles.
module arb_priority_fsm
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic if_req,
  input  logic ma_req,
  output logic if_gnt,
  output logic ma_gnt
);

  localparam int unsigned CNT_W = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             force_if;

  always_comb begin
    force_if     = if_req && (starve_cnt_q == LIMIT);
    if_gnt       = reset_n && if_req && (force_if || !ma_req);
    ma_gnt       = reset_n && ma_req && !force_if;
    starve_cnt_d = '0;
    if (if_req && !if_gnt) begin
      starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q
                                             : starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) starve_cnt_q <= '0;
    else          starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and memory-access stages onto one single-port memory
// and routes the one-cycle-latency read data back to the owning requester.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic [15:0] if_rdata,
  output logic        if_rvalid,
  input  logic        ma_req,
  input  logic        ma_we,
  input  logic [15:0] ma_addr,
  input  logic [15:0] ma_wdata,
  output logic        ma_gnt,
  output logic [15:0] ma_rdata,
  output logic        ma_rvalid,
  output logic [15:0] address_to_memory,
  output logic [15:0] data_to_memory,
  output logic        data_to_memory_write_en,
  input  logic [15:0] data_from_memory,
  output logic        stall_if
);

  resp_owner_e resp_q, resp_d;

  arb_priority_fsm #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk    (clk),
    .reset_n(reset_n),
    .if_req (if_req),
    .ma_req (ma_req),
    .if_gnt (if_gnt),
    .ma_gnt (ma_gnt)
  );

  always_comb begin
    address_to_memory       = '0;
    data_to_memory          = '0;
    data_to_memory_write_en = 1'b0;
    if (if_gnt) begin
      address_to_memory = if_addr;
    end else if (ma_gnt) begin
      address_to_memory       = ma_addr;
      data_to_memory          = ma_wdata;
      data_to_memory_write_en = ma_we;
    end
    stall_if = reset_n && if_req && !if_gnt;
  end

  always_comb begin
    resp_d = RESP_NONE;
    if (if_gnt)                resp_d = RESP_IF;
    else if (ma_gnt && !ma_we) resp_d = RESP_MA;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) resp_q <= RESP_NONE;
    else          resp_q <= resp_d;
  end

  // rvalid is also masked by reset_n so an in-flight read vanishes as soon as reset asserts.
  always_comb begin
    if_rvalid = reset_n && (resp_q == RESP_IF);
    ma_rvalid = reset_n && (resp_q == RESP_MA);
    if_rdata  = data_from_memory;
    ma_rdata  = data_from_memory;
  end

endmodule
